mult_seq_signed: RTL and testbench
==================================

# mult_seq_signed

Parametrised sequential shift-and-add multiplier, successor of the fixed 4-bit unsigned multiplier. Operand width is a parameter, each operation selects signed (two's complement) or unsigned mode, and a start/busy/done handshake gives a fixed, known latency. The block sits between a front end that supplies operand pairs and any datapath that consumes a 2·WIDTH-bit product. The result is held stable until the next operation is accepted.

## Interface
- WIDTH, default 8: operand width in bits, legal range 2..32; product is 2·WIDTH bits.
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- start_i  in  1  request; sampled only in IDLE.
- signed_i  in  1  1 = operands/result two's complement, 0 = unsigned; sampled with start_i.
- a_i  in  WIDTH  multiplicand; sampled with start_i.
- b_i  in  WIDTH  multiplier; sampled with start_i.
- busy_o  out  1  high in CALC and FIX.
- done_o  out  1  one-cycle pulse in DONE; y_o valid.
- y_o  out  2·WIDTH  product register output.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset state IDLE.
- IDLE: if start_i=1, load operands, clear accumulator, clear iteration counter, go to CALC; else stay. y_o keeps its last value.
- Load, signed_i=1: a_mag = |a_i|, b_mag = |b_i| (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1), no overflow). neg_flag = a_i[MSB] XOR b_i[MSB].
- Load, signed_i=0: a_mag = a_i, b_mag = b_i, neg_flag = 0.
- Multiplicand register is 2·WIDTH bits, zero-extended a_mag. Multiplier register is WIDTH bits.
- CALC, one iteration per cycle, WIDTH iterations: if mult[0]=1 then acc += mcand (2·WIDTH-bit, no carry out possible). Then mcand <<= 1, mult >>= 1, counter++. After iteration WIDTH-1, go to FIX.
- FIX: y_o <= neg_flag ? (~acc + 1) : acc, truncated to 2·WIDTH bits. Go to DONE.
- DONE: done_o=1 for this cycle only. Go to IDLE unconditionally. start_i in DONE is ignored.
- start_i while busy_o=1 or in DONE: ignored, no queuing, no effect on the current operation.
- Operand inputs may change freely after the sampling edge.
- Zero operand: still runs the full WIDTH iterations and yields 0. No early exit; latency is data-independent.
- Signed result range: -2^(2·WIDTH-2)+2^(WIDTH-1) .. 2^(2·WIDTH-2); always representable in 2·WIDTH bits.
- Unsigned max: (2^WIDTH-1)^2 fits in 2·WIDTH bits.

## Timing
- Reset (rst_i=1 at an edge): state=IDLE, y_o=0, busy_o=0, done_o=0, accumulator, operand registers and counter cleared. Reset has priority over all other inputs, including mid-CALC or mid-FIX; the in-flight operation is discarded and no done_o is produced.
- start_i is accepted at edge k (state IDLE). busy_o goes high after edge k.
- WIDTH iterations occur at edges k+1..k+WIDTH; the FSM enters FIX after edge k+WIDTH.
- y_o updates and done_o rises after edge k+WIDTH+1. done_o falls after edge k+WIDTH+2, and the FSM is back in IDLE.
- busy_o is high from after edge k until after edge k+WIDTH+1 (WIDTH+1 cycles).
- Earliest next accept is at edge k+WIDTH+3, so throughput is one product per WIDTH+3 cycles.
- y_o changes only at the FIX→DONE edge and on reset. It stays stable through DONE, IDLE and the next CALC.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=4, unsigned, a=15, b=15, start pulse at edge k -> done_o high only in the cycle after edge k+5; y_o=0xE1 (225); busy_o high for 5 cycles.
- WIDTH=4, signed, a=-8 (0x8), b=-8 -> y_o=0x40 (+64). Signed a=-3 (0xD), b=5 -> y_o=0xF1 (-15). Signed a=7, b=-8 -> y_o=0xC8 (-56).
- WIDTH=4, unsigned a=0, b=9 -> y_o=0x00 with the same 5-cycle latency. Then a=1, b=0 -> 0x00.
- start_i held high continuously with changing operands -> only operands present at each IDLE accept edge are used, and done_o pulses every 7 cycles. Starts issued during CALC/FIX/DONE cause no extra done_o.
- rst_i asserted for one cycle during the 2nd CALC iteration -> no done_o, y_o=0, busy_o=0 next cycle. A new start after reset gives the correct product.
- WIDTH=8 randomized (≥1000 ops, both modes) vs reference model -> every y_o matches at done_o; y_o unchanged between done_o pulses.

Source files
------------

// File: rtl/mult_seq_signed.sv
// Sequential shift-and-add multiplier, signed or unsigned per operation; one product every WIDTH+3 cycles.
// Latency WIDTH+1 cycles from the accept edge to done_o; start_i is only honoured in IDLE, with no queuing.
module mult_seq_signed #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   y_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mult;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_in;

    // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps cleanly to 2^(WIDTH-1).
    always_comb begin
        a_mag  = a_i;
        b_mag  = b_i;
        neg_in = 1'b0;
        if (signed_i) begin
            a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
            b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
            neg_in = a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mult   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            y_o    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mult   <= b_mag;
                        neg    <= neg_in;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // The accumulator cannot overflow: the magnitude product fits in 2*WIDTH bits.
                    if (mult[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    y_o    <= neg ? -acc : acc;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_signed.sv
// Bench for mult_seq_signed at WIDTH=4 (directed vectors, corner sequences) and WIDTH=8 (random vs model).
module tb_mult_seq_signed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4;
    logic [7:0] y4;

    logic       start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8;
    logic [15:0] y8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_seq_signed #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .signed_i(sgn4),
        .a_i(a4), .b_i(b4), .busy_o(busy4), .done_o(done4), .y_o(y4)
    );

    mult_seq_signed #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .signed_i(sgn8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .y_o(y8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        longint sa, sb, p;
        logic [63:0] m;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        m = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & m;
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string name);
        logic [7:0] prev;
        int cyc, busy_n;
        bit stable;
        prev   = y4;
        stable = 1'b1;
        sgn4 = s; a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = ~a; b4 = ~b; sgn4 = ~s;
        cyc = 0; busy_n = 0;
        while (!done4 && cyc < 20) begin
            if (busy4) busy_n++;
            if (y4 !== prev) stable = 1'b0;
            tick();
            cyc++;
        end
        check({name, " y"}, y4, exp);
        check({name, " latency"}, cyc, 5);
        check({name, " busy_cycles"}, busy_n, 5);
        check({name, " y_held"}, stable, 1);
        tick();
        check({name, " done_fall"}, done4, 0);
        check({name, " busy_idle"}, busy4, 0);
        check({name, " y_after"}, y4, exp);
    endtask

    typedef struct {
        logic       s;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] y;
        string      name;
    } vec_t;

    initial begin
        vec_t vecs[9];
        logic [7:0] q4[$];
        logic [15:0] last8;
        int cyc, gap;
        bit stable;
        logic [63:0] exp8;

        vecs[0] = '{1'b0, 4'hF, 4'hF, 8'hE1, "u15x15"};
        vecs[1] = '{1'b1, 4'h8, 4'h8, 8'h40, "s-8x-8"};
        vecs[2] = '{1'b1, 4'hD, 4'h5, 8'hF1, "s-3x5"};
        vecs[3] = '{1'b1, 4'h7, 4'h8, 8'hC8, "s7x-8"};
        vecs[4] = '{1'b0, 4'h0, 4'h9, 8'h00, "u0x9"};
        vecs[5] = '{1'b0, 4'h1, 4'h0, 8'h00, "u1x0"};
        vecs[6] = '{1'b1, 4'hF, 4'hF, 8'h01, "s-1x-1"};
        vecs[7] = '{1'b0, 4'h8, 4'h8, 8'h40, "u8x8"};
        vecs[8] = '{1'b1, 4'h8, 4'h7, 8'hC8, "s-8x7"};

        tick();
        tick();
        check("reset y4", y4, 0);
        check("reset busy4", busy4, 0);
        check("reset done4", done4, 0);
        check("reset y8", y8, 0);
        rst = 1'b0;
        tick();
        check("idle busy4", busy4, 0);

        foreach (vecs[i]) run4(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].name);

        // start held high with fresh operands every cycle: accepts land every 7 cycles.
        start4 = 1'b1;
        for (int t = 0; t < 35; t++) begin
            sgn4 = 1'($urandom);
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            if (t % 7 == 0) q4.push_back(8'(ref_mul(sgn4, 32'(a4), 32'(b4), 4)));
            tick();
            check("cont done", done4, (t % 7 == 5));
            check("cont busy", busy4, (t % 7 <= 4));
            if (t % 7 == 5 && q4.size() > 0) check("cont y", y4, q4.pop_front());
        end
        start4 = 1'b0;
        tick();

        // Reset during the second CALC iteration discards the operation.
        run4(1'b0, 4'hF, 4'hF, 8'hE1, "pre_rst");
        sgn4 = 1'b0; a4 = 4'hF; b4 = 4'hE; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst y4", y4, 0);
        check("rst busy4", busy4, 0);
        check("rst done4", done4, 0);
        cyc = 0;
        for (int t = 0; t < 8; t++) begin
            if (done4) cyc++;
            tick();
        end
        check("rst no_done", cyc, 0);
        run4(1'b1, 4'hD, 4'h5, 8'hF1, "post_rst");

        // Randomised WIDTH=8 operations against the reference model.
        last8 = y8;
        for (int n = 0; n < 1000; n++) begin
            stable = 1'b1;
            sgn8 = 1'($urandom);
            a8 = pick8();
            b8 = pick8();
            exp8 = ref_mul(sgn8, 32'(a8), 32'(b8), 8);
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            cyc = 0;
            while (!done8 && cyc < 30) begin
                if (y8 !== last8) stable = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
                start8 = 1'($urandom);
                tick();
                cyc++;
            end
            start8 = 1'b0;
            check("rand y8", y8, exp8);
            check("rand latency8", cyc, 9);
            last8 = y8;
            gap = 1 + $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                if (y8 !== last8) stable = 1'b0;
                if (g == 0) check("rand done_fall8", done8, 0);
            end
            check("rand y8_held", stable, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
